// File: rtl/branch_unit.sv
// Instruction pointer and branch unit with hardware return-address stack.
// Falling-edge state, conditional JMP/CALL/RET, sticky OVF/UNF stack errors.
//
// Ports:
//   CLK, RST        : clock (falling edge active), async active-high reset
//   EN              : advance enable; 0 holds every piece of state
//   JMP_INST        : conditional jump strobe
//   CALL_INST       : conditional call strobe
//   RET_INST        : conditional return strobe (priority RET > CALL > JMP)
//   OP              : {required flag value, flag select}
//   FLAGS           : condition flag vector, 2**CW bits
//   TARGET          : jump/call destination
//   Addr            : current instruction address
//   TAKEN           : combinational, a redirect happens at the next edge
//   SP              : number of valid return-stack entries
//   FULL, EMPTY     : stack occupancy status
//   OVF, UNF        : sticky call-on-full / return-on-empty flags
module branch_unit #(
  parameter int AW = 8,
  parameter int DEPTH = 4,
  parameter int CW = 3,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic                         JMP_INST,
  input  logic                         CALL_INST,
  input  logic                         RET_INST,
  input  logic [CW:0]                  OP,
  input  logic [(2**CW)-1:0]           FLAGS,
  input  logic [AW-1:0]                TARGET,
  output logic [AW-1:0]                Addr,
  output logic                         TAKEN,
  output logic [$clog2(DEPTH+1)-1:0]   SP,
  output logic                         FULL,
  output logic                         EMPTY,
  output logic                         OVF,
  output logic                         UNF
);

  localparam int SPW = $clog2(DEPTH+1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]  addr_q;
  logic [AW-1:0]  addr_d;
  logic [AW-1:0]  addr_inc;
  logic [SPW-1:0] sp_q;
  logic [SPW-1:0] sp_d;
  logic [AW-1:0]  stack_q [DEPTH];
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  top_idx;
  logic           push;
  logic           cond;
  logic           full;
  logic           empty;
  logic           ret_sel;
  logic           call_sel;
  logic           jmp_sel;
  logic           do_ret;
  logic           do_call;
  logic           do_jmp;
  logic           ovf_hit;
  logic           unf_hit;
  logic           ovf_q;
  logic           unf_q;

  assign cond     = (FLAGS[OP[CW-1:0]] == OP[CW]);
  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign addr_inc = addr_q + AW'(1);

  // SP never exceeds DEPTH <= 2**IW, so the low bits
  // address the slot and wrap correctly for top = SP-1.
  assign push_idx = sp_q[IW-1:0];
  assign top_idx  = push_idx - IW'(1);

  // Strobe priority: RET over CALL over JMP.
  assign ret_sel  = RET_INST;
  assign call_sel = CALL_INST & ~RET_INST;
  assign jmp_sel  = JMP_INST & ~CALL_INST & ~RET_INST;

  assign do_ret   = EN & ret_sel & cond & ~empty;
  assign do_call  = EN & call_sel & cond & ~full;
  assign do_jmp   = EN & jmp_sel & cond;
  assign unf_hit  = EN & ret_sel & cond & empty;
  assign ovf_hit  = EN & call_sel & cond & full;

  assign TAKEN    = do_ret | do_call | do_jmp;

  always_comb begin
    addr_d = addr_inc;
    sp_d   = sp_q;
    push   = 1'b0;
    unique case (1'b1)
      do_ret: begin
        addr_d = stack_q[top_idx];
        sp_d   = sp_q - SPW'(1);
      end
      do_call: begin
        addr_d = TARGET;
        sp_d   = sp_q + SPW'(1);
        push   = 1'b1;
      end
      do_jmp: begin
        addr_d = TARGET;
      end
      default: begin
      end
    endcase
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      addr_q <= RESET_VEC;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else if (EN) begin
      addr_q <= addr_d;
      sp_q   <= sp_d;
      if (push) begin
        stack_q[push_idx] <= addr_inc;
      end
      if (ovf_hit) begin
        ovf_q <= 1'b1;
      end
      if (unf_hit) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign Addr  = addr_q;
  assign SP    = sp_q;
  assign FULL  = full;
  assign EMPTY = empty;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed plan plus random traffic,
// checked against a queue-based return-stack model.
module tb_branch_unit;

  localparam int AW  = 8;
  localparam int DEP = 4;
  localparam int CW  = 3;
  localparam int FW  = 2**CW;
  localparam int SPW = $clog2(DEP+1);
  localparam logic [AW-1:0] RV = 8'h00;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic           EN = 1'b0;
  logic           JMP_INST = 1'b0;
  logic           CALL_INST = 1'b0;
  logic           RET_INST = 1'b0;
  logic [CW:0]    OP = '0;
  logic [FW-1:0]  FLAGS = '0;
  logic [AW-1:0]  TARGET = '0;
  logic [AW-1:0]  Addr;
  logic           TAKEN;
  logic [SPW-1:0] SP;
  logic           FULL;
  logic           EMPTY;
  logic           OVF;
  logic           UNF;

  branch_unit #(
    .AW(AW), .DEPTH(DEP), .CW(CW), .RESET_VEC(RV)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .JMP_INST(JMP_INST), .CALL_INST(CALL_INST),
    .RET_INST(RET_INST), .OP(OP), .FLAGS(FLAGS),
    .TARGET(TARGET), .Addr(Addr), .TAKEN(TAKEN),
    .SP(SP), .FULL(FULL), .EMPTY(EMPTY),
    .OVF(OVF), .UNF(UNF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit   taken;
    int   addr;
    int   sp;
    bit   ovf;
    bit   unf;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;

  // Reference model: plain integers and a queue as the stack.
  int   m_pc;
  int   m_stk[$];
  bit   m_ovf;
  bit   m_unf;

  localparam logic [CW:0]   OPU = 4'b1000;
  localparam logic [FW-1:0] FL1 = 8'h01;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_pc = int'(RV);
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  function automatic exp_t m_step(
    input bit en, input bit j, input bit c, input bit r,
    input int op, input int fl, input int tg);
    exp_t e;
    int   sel;
    bit   want;
    bit   cnd;
    bit   tk;
    sel  = op % FW;
    want = bit'(op / FW);
    cnd  = (((fl >> sel) & 1) == int'(want));
    tk   = 0;
    if (en) begin
      if (r) begin
        if (cnd && m_stk.size() > 0) begin
          m_pc = m_stk.pop_back();
          tk = 1;
        end else begin
          if (cnd) m_unf = 1;
          m_pc = (m_pc + 1) % 256;
        end
      end else if (c) begin
        if (cnd && m_stk.size() < DEP) begin
          m_stk.push_back((m_pc + 1) % 256);
          m_pc = tg;
          tk = 1;
        end else begin
          if (cnd) m_ovf = 1;
          m_pc = (m_pc + 1) % 256;
        end
      end else if (j && cnd) begin
        m_pc = tg;
        tk = 1;
      end else begin
        m_pc = (m_pc + 1) % 256;
      end
    end
    e.taken = tk;
    e.addr  = m_pc;
    e.sp    = m_stk.size();
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    return e;
  endfunction

  // Drive one cycle of stimulus on the rising edge; the DUT
  // samples it on the following falling edge.
  task automatic step(
    input bit en, input bit j, input bit c, input bit r,
    input logic [CW:0] op, input logic [FW-1:0] fl,
    input logic [AW-1:0] tg);
    @(posedge CLK);
    EN = en;
    JMP_INST = j;
    CALL_INST = c;
    RET_INST = r;
    OP = op;
    FLAGS = fl;
    TARGET = tg;
    q.push_back(m_step(en, j, c, r, int'(op), int'(fl), int'(tg)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, '0, '0, '0);
  endtask

  // Reset asserted mid-phase, away from any clock edge.
  task automatic do_reset();
    @(posedge CLK);
    EN = 0;
    JMP_INST = 0;
    CALL_INST = 0;
    RET_INST = 0;
    #2;
    RST = 1;
    #1;
    m_reset();
    chk("rst_addr", int'(Addr), int'(RV));
    chk("rst_sp", int'(SP), 0);
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_full", int'(FULL), 0);
    chk("rst_ovf", int'(OVF), 0);
    chk("rst_unf", int'(UNF), 0);
    chk("rst_taken", int'(TAKEN), 0);
    @(posedge CLK);
    RST = 0;
  endtask

  // Monitor: TAKEN mid high phase, registered state after the edge.
  initial begin
    exp_t e;
    bit   t;
    forever begin
      @(posedge CLK);
      #3;
      if (q.size() > 0) begin
        t = TAKEN;
        @(negedge CLK);
        #1;
        e = q.pop_front();
        chk("taken", int'(t), int'(e.taken));
        chk("addr", int'(Addr), e.addr);
        chk("sp", int'(SP), e.sp);
        chk("full", int'(FULL), int'(e.sp == DEP));
        chk("empty", int'(EMPTY), int'(e.sp == 0));
        chk("ovf", int'(OVF), int'(e.ovf));
        chk("unf", int'(UNF), int'(e.unf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no end, expected end");
    $fatal(1);
  end

  initial begin
    m_reset();
    do_reset();
    idle(3);
    // Wrap and stall
    step(1, 1, 0, 0, OPU, FL1, 8'hFF);
    idle(1);
    step(0, 1, 0, 0, OPU, FL1, 8'h55);
    step(0, 0, 1, 0, OPU, FL1, 8'h66);
    // Conditional jump on FLAGS[2]
    step(1, 1, 0, 0, 4'b1010, 8'b0000_0100, 8'h40);
    step(1, 1, 0, 0, 4'b0010, 8'b0000_0100, 8'h20);
    // Nested call/return
    step(1, 1, 0, 0, OPU, FL1, 8'h10);
    step(1, 0, 1, 0, OPU, FL1, 8'h80);
    step(1, 0, 1, 0, OPU, FL1, 8'hC0);
    step(1, 0, 0, 1, OPU, FL1, 8'h00);
    step(1, 0, 0, 1, OPU, FL1, 8'h00);
    // Overflow then underflow
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 0, OPU, FL1, AW'(8'h20 + 8'(i*16)));
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, OPU, FL1, '0);
    idle(2);
    // Priority: CALL+RET+JMP together with SP=1
    do_reset();
    step(1, 0, 1, 0, OPU, FL1, 8'h30);
    step(1, 1, 1, 1, OPU, FL1, 8'h90);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(9) != 0),
           ($urandom_range(3) == 0),
           ($urandom_range(3) == 0),
           ($urandom_range(3) == 0),
           (CW+1)'($urandom), FW'($urandom), AW'($urandom));
    end
    // Async reset with three return addresses stacked
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 0, OPU, FL1, AW'(8'h50 + 8'(i)));
    end
    do_reset();
    idle(2);
    repeat (3) @(negedge CLK);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised instruction-pointer and branch unit that replaces the fixed 8-bit PC/jump path of the core. It holds the program address, resolves conditional jumps against a selectable flag bit, and adds conditional CALL/RET through an internal hardware return-address stack of configurable depth. It also adds a stall enable and sticky stack-error reporting. It sits between the instruction decoder (JMP/CALL/RET strobes, OP, IMM target) and program memory (`Addr`).

## Interface
- `AW`, 8: program address width in bits.
- `DEPTH`, 4: return-stack entries, minimum 1.
- `CW`, 3: condition-select width. The flag vector is 2**CW bits.
- `RESET_VEC`, 0: value loaded into `Addr` on reset.

- `CLK`  in  1: single clock. All state updates on the falling edge.
- `RST`  in  1: asynchronous, active-high reset.
- `EN`  in  1: advance enable. When 0, all state holds.
- `JMP_INST`  in  1: conditional jump strobe.
- `CALL_INST`  in  1: conditional call strobe.
- `RET_INST`  in  1: conditional return strobe.
- `OP`  in  CW+1: `OP[CW-1:0]` selects the flag bit. `OP[CW]` is the required flag value.
- `FLAGS`  in  2**CW: condition flags. The decoder ties one bit high for unconditional use.
- `TARGET`  in  AW: jump/call destination (IMM field).
- `Addr`  out  AW: current instruction address.
- `TAKEN`  out  1: combinational. A redirect occurs at the next falling edge.
- `SP`  out  clog2(DEPTH+1): number of valid stack entries.
- `FULL`  out  1: `SP == DEPTH`.
- `EMPTY`  out  1: `SP == 0`.
- `OVF`  out  1: sticky flag. A CALL was attempted while the stack was full.
- `UNF`  out  1: sticky flag. A RET was attempted while the stack was empty.

## Operation
- Condition: `COND = (FLAGS[OP[CW-1:0]] == OP[CW])`.
- Each strobe is decoded in priority order RET > CALL > JMP. Lower-priority strobes asserted in the same cycle are ignored.
- Default action: `Addr <= Addr + 1`, modulo 2**AW (wraps from all-ones to 0).
- JMP:
  - If COND, then `Addr <= TARGET`.
  - Otherwise, the default increment applies.
- CALL:
  - If COND and not FULL: push `Addr+1` (wrapped) onto the stack, set `SP <= SP+1`, and load `Addr <= TARGET`.
  - If COND and FULL: no push, no redirect, default increment, and `OVF <= 1`.
  - If not COND: default increment.
- RET:
  - If COND and not EMPTY: `Addr <= top of stack` and `SP <= SP-1`.
  - If COND and EMPTY: default increment and `UNF <= 1`.
  - If not COND: default increment.
- `TAKEN` is 1 only for a JMP, CALL or RET that actually redirects `Addr`. Suppressed CALL/RET, no strobe, and `EN = 0` all give `TAKEN = 0`.
- `EN = 0`: `Addr`, `SP`, stack contents, `OVF` and `UNF` all hold. Strobes are ignored.
- The stack is LIFO. The top entry is index `SP-1`. Popped entries are not cleared.
- `OVF` and `UNF` are cleared only by `RST`.

## Timing
- Inputs are sampled at the falling edge of `CLK`. `Addr` is valid after that edge and stays stable through the following high phase. This lets the register bank capture data during one instruction.
- Latency:
  - A redirect is visible on `Addr` one falling edge after the strobe is sampled.
  - A return address pushed at edge N is available to a RET sampled at edge N+1.
- `TAKEN` is combinational from `EN`, the strobes, `OP`, `FLAGS`, `FULL` and `EMPTY`. There is no path from `TARGET` to `TAKEN`.
- `FULL`, `EMPTY` and `SP` are registered-derived and change only on the falling edge.
- Reset behaviour:
  - `RST` high forces, immediately and independent of `CLK`: `Addr = RESET_VEC`, `SP = 0`, `EMPTY = 1`, `FULL = 0`, `OVF = 0`, `UNF = 0`, all stack entries 0.
  - Reset asserted mid-call-chain discards all return addresses.
  - The first falling edge after `RST` deasserts applies normal operation starting from `RESET_VEC`.

## Test plan
- Reset and increment (`AW=8`): assert `RST`, release, run 3 edges with no strobes, `EN=1` -> `Addr` = 0, 1, 2, 3; `EMPTY=1`.
- Wrap-around and stall: `Addr=0xFF`, no strobe -> `Addr=0x00`. With `EN=0` for 2 edges, `Addr` holds `0x00` and `TAKEN=0`.
- Conditional jump: set `FLAGS=8'b0000_0100`.
  - `JMP_INST` with `OP=4'b1010`, `TARGET=0x40` -> `TAKEN=1`, `Addr=0x40`.
  - Same with `OP=4'b0010` -> `TAKEN=0`, `Addr` increments.
- Call/return nesting (`DEPTH=4`): CALL taken at `Addr=0x10` to `0x80`, then CALL taken at `0x80` to `0xC0` -> `SP=2`.
  - First RET -> `Addr=0x81`.
  - Second RET -> `Addr=0x11`, `SP=0`, `EMPTY=1`.
- Overflow and underflow:
  - Four taken CALLs -> `FULL=1`. A fifth CALL -> `Addr` increments, `SP=4`, `OVF=1`.
  - After 4 RETs, a further RET -> `UNF=1`, `Addr` increments.
  - Both flags stay set until `RST`.
- Priority and async reset:
  - `CALL_INST` and `RET_INST` together with `SP=1`, `COND=1` -> RET executes and `SP=0`.
  - Pulse `RST` between clock edges with `SP=3` -> `SP=0` and `Addr=RESET_VEC` before the next edge.
